// File: rtl/write_back.sv
// Write-back stage of the Beta pipeline: latches PC/IR/Y from the memory
// stage, selects the RF write data and owns the 32x32 register file.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   stall_wb                 hold WB registers, suppress RF write
//   pc_wb_next/ir_wb_next/
//   y_wb_next                values entering WB
//   mem_rd                   load data for the instruction in WB
//   rf_ra1/rf_rd1,
//   rf_ra2/rf_rd2            combinational read ports (write-through)
//   wb_we/wb_rc/wb_wd        forwarding info for the instruction in WB
module write_back #(
  parameter logic [31:0] NOP_INST = 32'h83FF_F800,
  parameter int          XP_IDX   = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_wb,
  input  logic [31:0] pc_wb_next,
  input  logic [31:0] ir_wb_next,
  input  logic [31:0] y_wb_next,
  input  logic [31:0] mem_rd,
  input  logic [4:0]  rf_ra1,
  output logic [31:0] rf_rd1,
  input  logic [4:0]  rf_ra2,
  output logic [31:0] rf_rd2,
  output logic        wb_we,
  output logic [4:0]  wb_rc,
  output logic [31:0] wb_wd
);

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_LDR = 6'h1F;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [4:0] R31    = 5'd31;
  localparam logic [4:0] XP     = 5'(XP_IDX);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] y_q, y_d;
  logic [31:0] rf_q [32];

  logic [5:0]  op;
  logic [4:0]  rc;
  logic        is_ld, is_br, is_alu;
  logic        wr_cls;
  logic [31:0] wd;
  logic        unused_ir;

  // Pipeline registers hold while stalled
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    y_d  = y_q;
    if (!stall_wb) begin
      pc_d = pc_wb_next;
      ir_d = ir_wb_next;
      y_d  = y_wb_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
      ir_q <= NOP_INST;
      y_q  <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      y_q  <= y_d;
    end
  end

  assign op        = ir_q[31:26];
  assign rc        = ir_q[25:21];
  assign unused_ir = ^ir_q[20:0];

  assign is_ld  = (op == OP_LD) || (op == OP_LDR);
  assign is_br  = (op == OP_JMP) || (op == OP_BEQ) ||
                  (op == OP_BNE);
  assign is_alu = op[5];

  always_comb begin
    wr_cls = 1'b0;
    wd     = y_q;
    unique case (1'b1)
      is_ld: begin
        wr_cls = 1'b1;
        wd     = mem_rd;
      end
      is_br: begin
        wr_cls = 1'b1;
        wd     = pc_q;
      end
      is_alu: begin
        wr_cls = 1'b1;
        wd     = y_q;
      end
      default: ;
    endcase
  end

  assign wb_we = wr_cls & (rc != R31) & ~stall_wb & ~rst;
  assign wb_rc = rst ? R31 : rc;
  assign wb_wd = rst ? pc_q : wd;

  // Entry 31 is never written, so it stays zero after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_rc] <= wb_wd;
    end
  end

  // Write-through: a read of the register being written sees new data
  assign rf_rd1 = (rf_ra1 == R31) ? '0 :
                  (wb_we && rf_ra1 == wb_rc) ? wb_wd :
                  rf_q[rf_ra1];
  assign rf_rd2 = (rf_ra2 == R31) ? '0 :
                  (wb_we && rf_ra2 == wb_rc) ? wb_wd :
                  rf_q[rf_ra2];

  // Exception branch is an ordinary BNE writing PC+4 into XP
  always_comb begin
    if (wb_we && op == OP_BNE && rc == XP)
      assert (wb_wd == pc_q);
  end

endmodule

// File: tb/tb_write_back.sv
// Bench for write_back: directed plan steps plus random traffic
// checked against a behavioural register-file model.
module tb_write_back;

  localparam logic [31:0] NOP = 32'h83FF_F800;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_wb;
  logic [31:0] pc_wb_next, ir_wb_next, y_wb_next, mem_rd;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rc;
  logic [31:0] wb_wd;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_ir, m_y;
  logic [31:0] m_rf [32];

  write_back dut (
    .clk(clk), .rst(rst), .stall_wb(stall_wb),
    .pc_wb_next(pc_wb_next), .ir_wb_next(ir_wb_next),
    .y_wb_next(y_wb_next), .mem_rd(mem_rd),
    .rf_ra1(rf_ra1), .rf_rd1(rf_rd1),
    .rf_ra2(rf_ra2), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rc(wb_rc), .wb_wd(wb_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [4:0] rc);
    logic [31:0] r;
    r = $urandom;
    return {op, rc, r[20:0]};
  endfunction

  task automatic m_reset();
    m_pc = 0;
    m_ir = NOP;
    m_y  = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  // What the instruction now in WB should do, from opcode class rules
  task automatic m_wb(input logic st, input logic [31:0] md,
                      output logic we, output logic [4:0] rc,
                      output logic [31:0] wd);
    int op;
    op = int'(m_ir[31:26]);
    rc = m_ir[25:21];
    we = 1'b1;
    if (op == 'h18 || op == 'h1F) wd = md;
    else if (op >= 'h1B && op <= 'h1D) wd = m_pc;
    else if (op >= 'h20) wd = m_y;
    else begin
      wd = m_y;
      we = 1'b0;
    end
    if (rc == 31 || st) we = 1'b0;
  endtask

  function automatic logic [31:0] rd_exp(input logic [4:0] a,
                                         input logic we,
                                         input logic [4:0] rc,
                                         input logic [31:0] wd);
    if (a == 31) return 0;
    if (we && a == rc) return wd;
    return m_rf[a];
  endfunction

  task automatic step(input logic st,
                      input logic [31:0] pcn, irn, yn, md,
                      input logic [4:0] a1, a2);
    logic we_e;
    logic [4:0] rc_e;
    logic [31:0] wd_e;
    @(negedge clk);
    stall_wb   = st;
    pc_wb_next = pcn;
    ir_wb_next = irn;
    y_wb_next  = yn;
    mem_rd     = md;
    rf_ra1     = a1;
    rf_ra2     = a2;
    #1;
    m_wb(st, md, we_e, rc_e, wd_e);
    chk("wb_we", 32'(wb_we), 32'(we_e));
    if (we_e) begin
      chk("wb_rc", 32'(wb_rc), 32'(rc_e));
      chk("wb_wd", wb_wd, wd_e);
    end
    chk("rf_rd1", rf_rd1, rd_exp(a1, we_e, rc_e, wd_e));
    chk("rf_rd2", rf_rd2, rd_exp(a2, we_e, rc_e, wd_e));
    @(posedge clk);
    if (we_e) m_rf[rc_e] = wd_e;
    if (!st) begin
      m_pc = pcn;
      m_ir = irn;
      m_y  = yn;
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_rc", 32'(wb_rc), 31);
    chk("rst_wd", wb_wd, 0);
  endtask

  initial begin
    rst = 1'b1;
    stall_wb = 0;
    pc_wb_next = 0;
    ir_wb_next = NOP;
    y_wb_next = 0;
    mem_rd = 0;
    rf_ra1 = 0;
    rf_ra2 = 0;
    m_reset();

    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;

    repeat (3) step(0, 0, NOP, 0, 0, 0, 31);
    for (int a = 0; a < 32; a++) begin
      rf_ra1 = 5'(a);
      #1;
      chk("rst_rf", rf_rd1, 0);
    end

    // ADD rc=5: bypass in WB cycle, then from storage
    step(0, 32'h4, mk(6'h20, 5), 32'hDEAD_BEEF, 0, 5, 0);
    step(0, 32'h8, NOP, 0, 0, 5, 5);
    chk("add_byp", wb_wd, 32'hDEAD_BEEF);
    step(0, 32'hC, NOP, 0, 0, 5, 0);
    chk("add_reg", rf_rd1, 32'hDEAD_BEEF);

    // LD rc=7 writes load data, not the address
    step(0, 32'h10, mk(6'h18, 7), 32'hFFFF_0000, 0, 0, 0);
    step(0, 32'h14, NOP, 0, 32'h1234_5678, 7, 0);
    step(0, 32'h18, NOP, 0, 0, 7, 0);
    chk("ld_reg", rf_rd1, 32'h1234_5678);

    // BEQ rc=30 writes PC+4
    step(0, 32'h104, mk(6'h1C, 30), 32'h55, 0, 0, 0);
    step(0, 32'h108, NOP, 0, 0, 30, 0);
    step(0, 32'h10C, NOP, 0, 0, 30, 0);
    chk("beq_reg", rf_rd1, 32'h0000_0104);

    // JMP rc=31, ST and opcode 0 write nothing
    step(0, 32'h200, mk(6'h1B, 31), 0, 0, 0, 0);
    step(0, 32'h204, mk(6'h19, 5), 32'h77, 0, 0, 31);
    chk("jmp31_rd2", rf_rd2, 0);
    step(0, 32'h208, mk(6'h00, 7), 32'h99, 0, 5, 7);
    step(0, 32'h20C, NOP, 0, 0, 5, 7);
    chk("st_keep5", rf_rd1, 32'hDEAD_BEEF);
    chk("op0_keep7", rf_rd2, 32'h1234_5678);

    // ADD rc=3 held by stall for 2 cycles, writes on release
    step(0, 32'h300, mk(6'h20, 3), 32'hA5A5_0003, 0, 3, 0);
    step(1, 32'h304, mk(6'h20, 4), 32'h1, 0, 3, 3);
    step(1, 32'h308, mk(6'h20, 4), 32'h2, 0, 3, 3);
    chk("stall_nowr", rf_rd1, 0);
    step(0, 32'h30C, NOP, 0, 0, 3, 0);
    step(0, 32'h310, NOP, 0, 0, 3, 0);
    chk("stall_rel", rf_rd1, 32'hA5A5_0003);

    // Same, with async reset pulsed mid-stall
    step(0, 32'h400, mk(6'h20, 3), 32'h0BAD_0003, 0, 3, 0);
    step(1, 32'h404, NOP, 0, 0, 3, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outs();
    m_reset();
    #1 rst = 1'b0;
    step(1, 32'h408, NOP, 0, 0, 3, 5);
    step(0, 32'h40C, NOP, 0, 0, 3, 5);
    step(0, 32'h410, NOP, 0, 0, 3, 0);
    chk("rst_reg3", rf_rd1, 0);
    chk("rst_ir", dut.ir_q, NOP);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      logic [4:0] rc;
      op = 6'($urandom_range(0, 63));
      rc = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 4) == 0),
           $urandom, mk(op, rc), $urandom, $urandom,
           5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final (WB) stage of the five-stage Beta pipeline; sits directly downstream of the memory access stage.
- Latches the PC, IR and Y values handed down by the memory access stage and decodes the WB instruction.
- Selects register write data (PC+4, ALU result, or load data) and writes the 32x32 register file.
- The register file lives in this block; it serves two combinational read ports to the register-fetch stage and exports WB forwarding info.

Parameters:
- NOP_INST, 32'h83FF_F800, IR value loaded on reset (ADD R31,R31,R31).
- XP_IDX, 30, register index written by the exception branch; used only by assertions.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall_wb  in  1  hold WB pipeline registers; suppresses RF write
- pc_wb_next  in  32  PC+4 of the instruction entering WB
- ir_wb_next  in  32  IR entering WB
- y_wb_next  in  32  ALU result / address entering WB
- mem_rd  in  32  load data, valid during the WB cycle of a load
- rf_ra1  in  5  read port 1 address
- rf_rd1  out  32  read port 1 data
- rf_ra2  in  5  read port 2 address
- rf_rd2  out  32  read port 2 data
- wb_we  out  1  WB will write the RF this cycle (for forwarding)
- wb_rc  out  5  WB destination register
- wb_wd  out  32  WB write data

Behaviour:
- Reset (async, active-high):
  - pc_wb=0, ir_wb=NOP_INST, y_wb=0.
  - All 31 writable registers cleared to 0.
  - Outputs during reset: wb_we=0, wb_rc=31, wb_wd=pc_wb (0).
- Pipeline registers:
  - On posedge clk with stall_wb=0: pc_wb, ir_wb, y_wb load their *_next inputs.
  - With stall_wb=1: hold.
- Decode of ir_wb:
  - op = ir[31:26], rc = ir[25:21].
  - LD 0x18, LDR 0x1F: wd = mem_rd.
  - JMP 0x1B, BEQ 0x1C, BNE 0x1D: wd = pc_wb.
  - ALU 0x20-0x2F and ALUC 0x30-0x3F: wd = y_wb.
  - ST 0x19 and all other opcodes: no write; wd = y_wb.
- Write enable:
  - wb_we = write-class opcode AND rc != 31 AND stall_wb=0 AND not in reset.
  - wb_rc = rc; wb_wd = the selected wd.
- RF write: on posedge clk when wb_we=1, reg[rc] <= wd. Single-cycle latency: data is architecturally visible in the RF from the next cycle.
- RF read (combinational):
  - Address 31 returns 0.
  - Else if wb_we=1 and address == wb_rc, returns wb_wd (write-through bypass).
  - Else returns reg[address].
  - Both ports are independent and may read the same register.
- R31:
  - Never stored; reads always 0.
  - A write attempt to R31 is discarded and wb_we stays 0.
- Exceptions: the exception branch (BNE with rc=XP) writes PC+4 into XP via the ordinary branch path; no special case.
- Mid-operation reset: an in-flight WB write at the asserting edge is lost; pipeline returns to NOP; the RF is cleared.
- Simultaneous stall_wb and write-class instruction: no write. The instruction is retained and writes on the first unstalled cycle.
- Unknown opcode: treated as non-writing; must never produce X on wb_we.

Test Plan:
- Reset then idle 3 cycles -> wb_we=0; rf_rd1 for every address 0..31 reads 0.
- ADD with rc=5, y_wb_next=32'hDEAD_BEEF:
  - During the WB cycle: wb_we=1, wb_rc=5, rf_ra1=5 returns DEAD_BEEF via bypass.
  - Next cycle: read returns DEAD_BEEF from storage.
- LD with rc=7, mem_rd=32'h1234_5678, y_wb=32'hFFFF_0000 -> reg7=1234_5678.
- BEQ with rc=30, pc_wb=32'h0000_0104 -> reg30=0000_0104.
- JMP with rc=31 -> no write; wb_we=0; rf_rd2 at 31 reads 0.
- ST, and opcode 0x00 -> RF unchanged.
- ADD rc=3 with stall_wb held high 2 cycles:
  - No write while stalled; write of the latched value on release.
  - Same sequence with async rst pulsed mid-stall: reg3=0 and ir_wb=NOP_INST afterward.
